poly_voice_controller: RTL and testbench

- Polyphonic DDS voice bank with mixer for the MIDI synth.
- The SPI command decoder issues note-on/note-off commands per voice slot. Each active voice runs a 32-bit phase accumulator at the audio sample rate and produces a signed sawtooth.
- All voices are summed into one signed 24-bit sample for the audio output path.

---
 rtl/poly_voice_controller.sv | 122 ++++++++++++
 tb/tb_poly_voice_controller.sv | 136 +++++++++++++
 2 files changed

// File: rtl/poly_voice_controller.sv
// Polyphonic DDS sawtooth voice bank: per-slot phase accumulators advanced on an
// audio-rate tick, summed into one registered signed 24-bit sample.

module poly_voice_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        cmd_hit,
    input  logic        cmd_on,
    input  logic [31:0] cmd_inc,
    output logic [15:0] sample
);
    logic        active_q, active_d;
    logic [31:0] phase_q, phase_d;
    logic [31:0] inc_q, inc_d;

    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        inc_d    = inc_q;
        // A command on this slot takes priority over the tick advance.
        if (cmd_hit) begin
            active_d = cmd_on;
            phase_d  = '0;
            if (cmd_on) inc_d = cmd_inc;
        end else if (tick && active_q) begin
            phase_d = phase_q + inc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            phase_q  <= '0;
            inc_q    <= '0;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            inc_q    <= inc_d;
        end
    end

    // Offset-binary to two's complement: phase 0 maps to the most negative value.
    assign sample = active_q ? {~phase_q[31], phase_q[30:16]} : 16'h0000;
endmodule

module poly_voice_controller #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_DIV = 2083
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_SPI_note_status,
    input  logic [7:0]  i_SPI_voice_index,
    input  logic [31:0] i_SPI_tuning_code,
    input  logic [7:0]  i_SPI_velocity,
    input  logic        i_SPI_ready_flag,
    output logic [23:0] o_mixed_sample
);
    localparam int IW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int SW = 16 + IW;
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [8:0]    NV9      = 9'(NUM_VOICES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic          idx_valid;
    logic [NUM_VOICES-1:0]       cmd_hit;
    logic [NUM_VOICES-1:0][15:0] voice_sample;
    logic [SW-1:0] sum;
    logic [23:0]   mix_q, mix_d;
    logic          unused_velocity;

    assign unused_velocity = ^i_SPI_velocity;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    assign idx_valid = ({1'b0, i_SPI_voice_index} < NV9);

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign cmd_hit[v] = i_SPI_ready_flag && idx_valid &&
                            (i_SPI_voice_index[IW-1:0] == IW'(v));
        poly_voice_slot u_slot (
            .clk     (i_clk),
            .reset   (i_reset),
            .tick    (tick),
            .cmd_hit (cmd_hit[v]),
            .cmd_on  (i_SPI_note_status),
            .cmd_inc (i_SPI_tuning_code),
            .sample  (voice_sample[v])
        );
    end

    always_comb begin
        sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            sum = sum + {{(SW-16){voice_sample[v][15]}}, voice_sample[v]};
        end
    end

    // Mix is taken from registered (pre-update) voice state on the tick edge.
    always_comb begin
        mix_d = tick ? {{(24-SW){sum[SW-1]}}, sum} : mix_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
            mix_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            mix_q <= mix_d;
        end
    end

    assign o_mixed_sample = mix_q;
endmodule

// File: tb/tb_poly_voice_controller.sv
// Directed bench for poly_voice_controller with a short sample divider.

module tb_poly_voice_controller;
    localparam int NV  = 8;
    localparam int DIV = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        note_status = 1'b0;
    logic [7:0]  voice_index = 8'd0;
    logic [31:0] tuning = 32'd0;
    logic [7:0]  velocity = 8'd0;
    logic        ready = 1'b0;
    logic [23:0] mixed;

    int errors = 0;
    int checks = 0;
    int tcnt = 0;
    logic tick_exp;

    poly_voice_controller #(.NUM_VOICES(NV), .SAMPLE_DIV(DIV)) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_SPI_note_status (note_status),
        .i_SPI_voice_index (voice_index),
        .i_SPI_tuning_code (tuning),
        .i_SPI_velocity    (velocity),
        .i_SPI_ready_flag  (ready),
        .o_mixed_sample    (mixed)
    );

    always #5 clk = ~clk;

    // Reference tick counter, independent of the DUT.
    always @(posedge clk) begin
        if (rst) tcnt <= 0;
        else     tcnt <= (tcnt == DIV - 1) ? 0 : tcnt + 1;
    end
    assign tick_exp = (tcnt == DIV - 1);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int expv);
        logic [23:0] e;
        e = 24'(expv);
        checks++;
        assert (mixed === e) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, mixed, e);
        end
    endtask

    task automatic to_tick_edge();
        int n;
        n = 0;
        while (!tick_exp && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            errors++;
            checks++;
            $display("FAIL tick_timeout got=%0d exp=<100", n);
        end
    endtask

    task automatic run_tick();
        to_tick_edge();
        step();
    endtask

    task automatic cmd(input logic on, input logic [7:0] idx, input logic [31:0] tune);
        note_status = on;
        voice_index = idx;
        tuning      = tune;
        velocity    = 8'hA5;
        ready       = 1'b1;
        step();
        ready       = 1'b0;
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        check("reset_out", 0);
        run_tick(); check("idle_t1", 0);
        run_tick(); check("idle_t2", 0);
        run_tick(); check("idle_t3", 0);

        cmd(1'b1, 8'd5, 32'd20000000);
        run_tick(); check("v5_t1", -32768);
        run_tick(); check("v5_t2", -32463);
        step(); step(); check("v5_hold", -32463);
        run_tick(); check("v5_t3", -32158);

        cmd(1'b1, 8'd200, 32'h1234_5678);
        run_tick(); check("idx200_ignored", -31853);

        cmd(1'b0, 8'd5, 32'd0);
        run_tick(); check("v5_off", 0);
        cmd(1'b1, 8'd5, 32'd20000000);
        run_tick(); check("v5_reon", -32768);

        rst = 1'b1; step(); rst = 1'b0;
        check("reset_mid", 0);

        cmd(1'b1, 8'd0, 32'h4000_0000);
        cmd(1'b1, 8'd1, 32'h4000_0000);
        run_tick(); check("v01_t1", -65536);
        run_tick(); check("v01_t2", -32768);
        run_tick(); check("v01_t3", 0);
        run_tick(); check("v01_t4", 32768);
        run_tick(); check("v01_wrap", -65536);

        // Retrigger voice 0 on the tick edge: mix sees old state, voice 0 not advanced.
        to_tick_edge();
        cmd(1'b1, 8'd0, 32'd0);
        check("tick_cmd_mix", -32768);
        run_tick(); check("tick_cmd_n1", -32768);
        run_tick(); check("tick_cmd_n2", -16384);

        // Reset with a concurrent strobe: everything goes idle.
        rst = 1'b1;
        cmd(1'b1, 8'd4, 32'h1000_0000);
        check("reset_active", 0);
        rst = 1'b0;
        run_tick(); check("post_reset_t1", 0);
        run_tick(); check("post_reset_t2", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
